// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory arbiter.
// Requester ids double as bit positions in the per-requester port vectors.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORDS_PER_LINE = 8;

    localparam logic IC_ID = 1'b0;
    localparam logic DC_ID = 1'b1;

    // Turns a requester id into its bit in a 2-bit per-requester vector.
    function automatic logic [1:0] id_onehot(input logic id);
        return (id == DC_ID) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

    always_comb begin
        winner = IC_ID;
        if (req[IC_ID] && req[DC_ID]) begin
            winner = ~last_grant;
        end else if (req[DC_ID]) begin
            winner = DC_ID;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the L1 I-cache and D-cache: line-load bursts
// and single-word stores, one transaction at a time, round-robin on ties.
module mem_arbiter #(
    parameter int WORDS_PER_LINE = mem_arb_pkg::WORDS_PER_LINE,
    parameter int ADDR_W         = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_store,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*ADDR_W-1:0]   req_wdata,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [2:0]            rsp_word,
    output logic [ADDR_W-1:0]     rsp_data,
    output logic [1:0]            rsp_done,
    output logic                  mem_valid,
    output logic                  mem_store,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [ADDR_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [ADDR_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic                  owner,
    output mem_arb_pkg::state_t   dbg_state
);

    import mem_arb_pkg::*;

    localparam logic [2:0] LAST_WORD = 3'(WORDS_PER_LINE - 1);

    state_t            state;
    logic              last_grant;
    logic              winner;
    logic [2:0]        word_cnt;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_wdata;
    logic              sel_store;

    rr_arb2 u_rr_arb2 (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_comb begin
        sel_addr  = winner ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
        sel_wdata = winner ? req_wdata[2*ADDR_W-1:ADDR_W] : req_wdata[ADDR_W-1:0];
        sel_store = req_store[winner];
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Handshakes: a request is taken at the IDLE edge where req_valid is high; the
    // winner sees req_ready for exactly the next cycle. mem_valid holds its payload
    // until the edge with mem_ready=1. rsp_valid/rsp_done are single-cycle, owner bit only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            last_grant <= DC_ID;
            owner      <= IC_ID;
            word_cnt   <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_word   <= '0;
            rsp_data   <= '0;
            rsp_done   <= '0;
            mem_valid  <= 1'b0;
            mem_store  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_word  <= '0;
            rsp_data  <= '0;
            rsp_done  <= '0;

            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        req_ready  <= id_onehot(winner);
                        owner      <= winner;
                        last_grant <= winner;
                        word_cnt   <= '0;
                        mem_valid  <= 1'b1;
                        mem_store  <= sel_store;
                        mem_addr   <= sel_store ? sel_addr : {sel_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata  <= sel_store ? sel_wdata : '0;
                        state      <= REQ;
                    end
                end

                REQ: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_store <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        if (mem_store) begin
                            rsp_done <= id_onehot(owner);
                            state    <= DONE;
                        end else begin
                            state <= BURST;
                        end
                    end
                end

                BURST: begin
                    if (mem_rvalid) begin
                        rsp_valid <= id_onehot(owner);
                        rsp_word  <= word_cnt;
                        rsp_data  <= mem_rdata;
                        // The last word and the completion pulse land in the same DONE cycle.
                        if (word_cnt == LAST_WORD) begin
                            word_cnt <= '0;
                            rsp_done <= id_onehot(owner);
                            state    <= DONE;
                        end else begin
                            word_cnt <= word_cnt + 3'd1;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: tie arbitration, stores, line loads with and
// without gaps, spurious memory returns and reset in the middle of a burst.
module tb_mem_arbiter;

    localparam int W = 36;  // {owner, word[2:0], data[31:0]}

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_store;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [2:0]  rsp_word;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_done;
    logic        mem_valid;
    logic        mem_store;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;
    logic [1:0]  dbg_state;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    int checks   = 0;
    int failures = 0;
    int rsp_cnt  = 0;
    int done_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_item;

    mem_arbiter dut (
        .CLK        (clk),
        .RST        (rst),
        .req_valid  (req_valid),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_word   (rsp_word),
        .rsp_data   (rsp_data),
        .rsp_done   (rsp_done),
        .mem_valid  (mem_valid),
        .mem_store  (mem_store),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy       (busy),
        .owner      (owner),
        .dbg_state  (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    function automatic logic any_out();
        return |{req_ready, rsp_valid, rsp_word, rsp_data, rsp_done,
                 mem_valid, mem_store, mem_addr, mem_wdata, busy, owner};
    endfunction

    // Scoreboard: every returned load word must match the front of exp_q.
    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid != 2'b00) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    check("rsp_spurious", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("rsp_valid_bit", rsp_valid, onehot(exp_item[35]));
                    check("rsp_word", rsp_word, exp_item[34:32]);
                    check("rsp_data", rsp_data, exp_item[31:0]);
                    check("rsp_done_last", rsp_done,
                          (exp_item[34:32] == 3'd7) ? onehot(exp_item[35]) : 2'b00);
                end
            end
            if (rsp_done != 2'b00) done_cnt++;
        end
    end

    // Driver tasks
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic set_req(input logic id, input logic store, input logic [31:0] addr,
                           input logic [31:0] wdata);
        req_valid = onehot(id);
        req_store = store ? onehot(id) : 2'b00;
        if (id) begin
            req_addr  = {addr, 32'hFFFF_FFFC};
            req_wdata = {wdata, 32'h5555_5555};
        end else begin
            req_addr  = {32'hFFFF_FFFC, addr};
            req_wdata = {32'h5555_5555, wdata};
        end
    endtask

    task automatic start_load(input logic id, input logic [31:0] addr, input logic [31:0] exp_addr,
                              input int ready_delay, input bit spurious);
        mem_ready = 1'b0;
        set_req(id, 1'b0, addr, 32'h0);
        @(negedge clk);
        check("ld_req_ready", req_ready, onehot(id));
        check("ld_owner", owner, id);
        check("ld_mem_valid", mem_valid, 1'b1);
        check("ld_mem_store", mem_store, 1'b0);
        check("ld_mem_addr", mem_addr, exp_addr);
        req_valid = 2'b00;
        req_addr  = '1;
        for (int i = 0; i < ready_delay; i++) begin
            mem_rvalid = spurious;
            mem_rdata  = 32'hBAD0_0000;
            @(negedge clk);
            check("ld_hold_valid", mem_valid, 1'b1);
            check("ld_hold_addr", mem_addr, exp_addr);
            check("ld_hold_ready", req_ready, 2'b00);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        check("ld_in_burst", dbg_state, ST_BURST);
        check("ld_mem_valid_drop", mem_valid, 1'b0);
        check("ld_no_rsp_before_data", rsp_valid, 2'b00);
    endtask

    task automatic drive_burst(input logic id, input logic [31:0] base, input bit gaps,
                               input int nwords);
        for (int w = 0; w < nwords; w++) begin
            if (gaps) begin
                int g = $urandom_range(0, 3);
                repeat (g) begin
                    mem_rvalid = 1'b0;
                    @(negedge clk);
                end
            end
            mem_rvalid = 1'b1;
            mem_rdata  = base + 32'(w);
            exp_q.push_back({id, 3'(w), base + 32'(w)});
            @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    // Stimulus
    initial begin
        int rsp_before;
        int done_before;

        rst        = 1'b1;
        req_valid  = 2'b11;
        req_store  = 2'b11;
        req_addr   = {32'h0000_0200, 32'h0000_0100};
        req_wdata  = {32'h2222_0001, 32'h1111_0000};
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        repeat (3) @(negedge clk);
        check("rst_outputs_zero", any_out(), 1'b0);
        check("rst_state", dbg_state, ST_IDLE);

        // Tie held across reset release: I-cache first, then D-cache, then I-cache.
        rst = 1'b0;
        @(negedge clk);
        check("tie1_ready", req_ready, 2'b01);
        check("tie1_owner", owner, 1'b0);
        check("tie1_addr", mem_addr, 32'h0000_0100);
        check("tie1_wdata", mem_wdata, 32'h1111_0000);
        @(negedge clk);
        check("tie1_done", rsp_done, 2'b01);
        check("tie1_state_done", dbg_state, ST_DONE);
        @(negedge clk);
        check("tie_idle_gap", busy, 1'b0);
        check("tie_idle_no_ready", req_ready, 2'b00);
        @(negedge clk);
        check("tie2_ready", req_ready, 2'b10);
        check("tie2_owner", owner, 1'b1);
        check("tie2_addr", mem_addr, 32'h0000_0200);
        @(negedge clk);
        check("tie2_done", rsp_done, 2'b10);
        @(negedge clk);
        check("tie2_idle", busy, 1'b0);
        @(negedge clk);
        check("tie3_ready", req_ready, 2'b01);
        req_valid = 2'b00;
        wait_idle("tie_drain");

        // D-cache store, immediate mem_ready: IDLE, REQ, DONE.
        done_before = done_cnt;
        rsp_before  = rsp_cnt;
        mem_ready   = 1'b1;
        set_req(1'b1, 1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        @(negedge clk);
        req_valid = 2'b00;
        check("st_ready", req_ready, 2'b10);
        check("st_mem_store", mem_store, 1'b1);
        check("st_mem_addr", mem_addr, 32'h0000_0044);
        check("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("st_no_done_early", rsp_done, 2'b00);
        @(negedge clk);
        check("st_done", rsp_done, 2'b10);
        check("st_rsp_valid", rsp_valid, 2'b00);
        check("st_rsp_data", rsp_data, 32'h0);
        @(negedge clk);
        check("st_done_one_cycle", rsp_done, 2'b00);
        check("st_idle", busy, 1'b0);
        check("st_done_count", done_cnt - done_before, 1);
        check("st_no_rsp", rsp_cnt - rsp_before, 0);

        // D-cache line load, mem_ready after 2 cycles, back-to-back words.
        done_before = done_cnt;
        rsp_before  = rsp_cnt;
        start_load(1'b1, 32'h0000_1234, 32'h0000_1230, 2, 1'b0);
        drive_burst(1'b1, 32'h0000_00A0, 1'b0, 8);
        wait_idle("ld1_drain");
        check("ld1_words", rsp_cnt - rsp_before, 8);
        check("ld1_done", done_cnt - done_before, 1);
        check("ld1_queue_empty", exp_q.size(), 0);

        // Spurious mem_rvalid in IDLE and REQ, then a gappy I-cache burst.
        rsp_before  = rsp_cnt;
        done_before = done_cnt;
        mem_rvalid  = 1'b1;
        mem_rdata   = 32'hBAD0_0001;
        @(negedge clk);
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("spur_idle_rsp", rsp_valid, 2'b00);
        check("spur_idle_busy", busy, 1'b0);
        start_load(1'b0, 32'h0000_2007, 32'h0000_2000, 1, 1'b1);
        drive_burst(1'b0, 32'h0000_0D00, 1'b1, 8);
        wait_idle("ld2_drain");
        check("ld2_words", rsp_cnt - rsp_before, 8);
        check("ld2_done", done_cnt - done_before, 1);
        check("ld2_queue_empty", exp_q.size(), 0);

        // Reset after word 4 of a burst aborts it; next load starts at word 0.
        done_before = done_cnt;
        start_load(1'b1, 32'h0000_3000, 32'h0000_3000, 0, 1'b0);
        drive_burst(1'b1, 32'h0000_00B0, 1'b0, 5);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs_zero", any_out(), 1'b0);
        check("abort_state", dbg_state, ST_IDLE);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_0002;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        check("abort_still_zero", any_out(), 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", done_cnt - done_before, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        rsp_before  = rsp_cnt;
        done_before = done_cnt;
        start_load(1'b1, 32'h0000_300C, 32'h0000_3008, 0, 1'b0);
        drive_burst(1'b1, 32'h0000_00C0, 1'b0, 8);
        wait_idle("ld3_drain");
        check("ld3_words", rsp_cnt - rsp_before, 8);
        check("ld3_done", done_cnt - done_before, 1);
        check("ld3_queue_empty", exp_q.size(), 0);

        // After reset last_grant is back to D-cache, so a tie goes to I-cache.
        req_valid = 2'b11;
        req_store = 2'b11;
        req_addr  = {32'h0000_0300, 32'h0000_0400};
        mem_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        check("post_rst_tie", req_ready, 2'b01);
        wait_idle("final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
